// File: rtl/bus_map_pkg.sv
`default_nettype none
// ============================================================================
// bus_map_pkg -- address map, state and target encodings for bus_decoder
// Rev 1.0
// ============================================================================
package bus_map_pkg;

  localparam logic [7:0] c_io_page   = 8'hFE;  // IO window 0xFE00-0xFEFF
  localparam logic [7:0] c_vga_base  = 8'h00;
  localparam logic [7:0] c_vga_size  = 8'd4;
  localparam logic [7:0] c_uart_base = 8'h10;
  localparam logic [7:0] c_uart_size = 8'd2;
  localparam logic [7:0] c_err_dat   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TGT_RAM  = 2'd0,
    TGT_VGA  = 2'd1,
    TGT_UART = 2'd2,
    TGT_NONE = 2'd3
  } target_t;

endpackage
`default_nettype wire

// File: rtl/bus_addr_decode.sv
`default_nettype none
// ============================================================================
// bus_addr_decode -- 16-bit address to target select and target-local address
// Rev 1.0
// ============================================================================
module bus_addr_decode
  import bus_map_pkg::*;
(
  input  logic [15:0] i_addr,
  output target_t     o_target,
  output logic [15:0] o_local_addr
);

  logic [7:0] w_vga_off;
  logic [7:0] w_uart_off;

  // Offsets wrap below the base, so a single unsigned compare bounds each window.
  assign w_vga_off  = i_addr[7:0] - c_vga_base;
  assign w_uart_off = i_addr[7:0] - c_uart_base;

  always_comb begin
    o_target     = TGT_RAM;
    o_local_addr = i_addr;
    if (i_addr[15:8] == c_io_page) begin
      if (w_vga_off < c_vga_size) begin
        o_target     = TGT_VGA;
        o_local_addr = {8'h00, w_vga_off};
      end else if (w_uart_off < c_uart_size) begin
        o_target     = TGT_UART;
        o_local_addr = {8'h00, w_uart_off};
      end else begin
        o_target     = TGT_NONE;
        o_local_addr = {8'h00, i_addr[7:0]};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_decoder.sv
`default_nettype none
// ============================================================================
// bus_decoder -- single-access bus slave: decode, target handshake, ack/error
// Rev 1.0
// ============================================================================
module bus_decoder
  import bus_map_pkg::*;
#(
  parameter int RAM_WAIT = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_dat,
  input  logic        i_cs,
  input  logic        i_we,
  output logic [7:0]  o_dat,
  output logic        o_ack,
  output logic        o_buserr,
  output logic [15:0] o_ram_addr,
  output logic [7:0]  o_ram_dat,
  input  logic [7:0]  i_ram_dat,
  output logic        o_ram_cs,
  output logic        o_ram_we,
  output logic [1:0]  o_vga_addr,
  output logic [7:0]  o_vga_dat,
  input  logic [7:0]  i_vga_dat,
  output logic        o_vga_cs,
  output logic        o_vga_we,
  output logic        o_uart_addr,
  output logic [7:0]  o_uart_dat,
  input  logic [7:0]  i_uart_dat,
  output logic        o_uart_cs,
  output logic        o_uart_we,
  input  logic        i_uart_ack
);

  localparam logic [7:0] c_ram_wait = 8'(RAM_WAIT);
  localparam logic [7:0] c_timeout  = 8'(TIMEOUT);

  target_t     w_dec_target;
  logic [15:0] w_dec_addr;

  state_t      r_state;
  target_t     r_req_tgt;
  logic [15:0] r_req_addr;
  logic [7:0]  r_req_dat;
  logic        r_req_we;
  logic [7:0]  r_cnt;
  logic        r_abort;
  logic [7:0]  r_dat;
  logic        r_ack;
  logic        r_buserr;
  logic        r_ram_cs;
  logic        r_ram_we;
  logic        r_vga_cs;
  logic        r_vga_we;
  logic        r_uart_cs;
  logic        r_uart_we;

  logic        w_finish;
  logic        w_err;
  logic [7:0]  w_rd_dat;
  logic        w_abort;

  bus_addr_decode u_decode (
    .i_addr       (i_addr),
    .o_target     (w_dec_target),
    .o_local_addr (w_dec_addr)
  );

  // Completion condition of the current access, evaluated only while in ACCESS.
  always_comb begin
    w_finish = 1'b0;
    w_err    = 1'b0;
    w_rd_dat = c_err_dat;
    case (r_req_tgt)
      TGT_RAM: begin
        w_finish = (r_cnt == 8'd0);
        w_rd_dat = i_ram_dat;
      end
      TGT_VGA: begin
        w_finish = 1'b1;
        w_rd_dat = i_vga_dat;
      end
      TGT_UART: begin
        if (i_uart_ack) begin
          w_finish = 1'b1;
          w_rd_dat = i_uart_dat;
        end else if (r_cnt == c_timeout) begin
          w_finish = 1'b1;
          w_err    = 1'b1;
        end
      end
      default: begin
        w_finish = 1'b1;
        w_err    = 1'b1;
      end
    endcase
  end

  assign w_abort = r_abort | ~i_cs;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_req_tgt  <= TGT_RAM;
      r_req_addr <= 16'h0000;
      r_req_dat  <= 8'h00;
      r_req_we   <= 1'b0;
      r_cnt      <= 8'd0;
      r_abort    <= 1'b0;
      r_dat      <= 8'h00;
      r_ack      <= 1'b0;
      r_buserr   <= 1'b0;
      r_ram_cs   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_vga_cs   <= 1'b0;
      r_vga_we   <= 1'b0;
      r_uart_cs  <= 1'b0;
      r_uart_we  <= 1'b0;
    end else begin
      r_ack    <= 1'b0;
      r_buserr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_cs) begin
            r_state    <= ST_ACCESS;
            r_req_tgt  <= w_dec_target;
            r_req_addr <= w_dec_addr;
            r_req_dat  <= i_dat;
            r_req_we   <= i_we;
            r_abort    <= 1'b0;
            r_cnt      <= 8'd0;
            case (w_dec_target)
              TGT_RAM: begin
                r_ram_cs <= 1'b1;
                r_ram_we <= i_we;
                r_cnt    <= c_ram_wait;
              end
              TGT_VGA: begin
                r_vga_cs <= 1'b1;
                r_vga_we <= i_we;
              end
              TGT_UART: begin
                r_uart_cs <= 1'b1;
                r_uart_we <= i_we;
              end
              default: ;
            endcase
          end
        end
        ST_ACCESS: begin
          if (!i_cs) r_abort <= 1'b1;
          if (w_finish) begin
            r_state   <= ST_DONE;
            r_cnt     <= 8'd0;
            r_ram_cs  <= 1'b0;
            r_ram_we  <= 1'b0;
            r_vga_cs  <= 1'b0;
            r_vga_we  <= 1'b0;
            r_uart_cs <= 1'b0;
            r_uart_we <= 1'b0;
            r_ack     <= ~w_abort;
            r_buserr  <= ~w_abort & w_err;
            if (!w_abort && !r_req_we) r_dat <= w_rd_dat;
          end else if (r_req_tgt == TGT_UART) begin
            r_cnt <= r_cnt + 8'd1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_dat       = r_dat;
  assign o_ack       = r_ack;
  assign o_buserr    = r_buserr;
  assign o_ram_addr  = r_req_addr;
  assign o_ram_dat   = r_req_dat;
  assign o_ram_cs    = r_ram_cs;
  assign o_ram_we    = r_ram_we;
  assign o_vga_addr  = r_req_addr[1:0];
  assign o_vga_dat   = r_req_dat;
  assign o_vga_cs    = r_vga_cs;
  assign o_vga_we    = r_vga_we;
  assign o_uart_addr = r_req_addr[0];
  assign o_uart_dat  = r_req_dat;
  assign o_uart_cs   = r_uart_cs;
  assign o_uart_we   = r_uart_we;

endmodule
`default_nettype wire

// File: tb/tb_bus_decoder.sv
`default_nettype none
// ============================================================================
// tb_bus_decoder -- vector table + scoreboard bench for bus_decoder
// Rev 1.0
// ============================================================================
module tb_bus_decoder;

  localparam int T_RAM  = 0;
  localparam int T_VGA  = 1;
  localparam int T_UART = 2;
  localparam int T_NONE = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [7:0]  wdat;
  logic        cs, cs1, we;
  logic [7:0]  ram_dat, vga_dat, uart_dat;
  logic        uart_ack;

  logic [7:0]  d0_dat, d0_ram_dat, d0_vga_dat, d0_uart_dat;
  logic        d0_ack, d0_buserr, d0_ram_cs, d0_ram_we, d0_vga_cs, d0_vga_we;
  logic        d0_uart_addr, d0_uart_cs, d0_uart_we;
  logic [15:0] d0_ram_addr;
  logic [1:0]  d0_vga_addr;

  logic [7:0]  d1_dat, d1_ram_dat, d1_vga_dat, d1_uart_dat;
  logic        d1_ack, d1_buserr, d1_ram_cs, d1_ram_we, d1_vga_cs, d1_vga_we;
  logic        d1_uart_addr, d1_uart_cs, d1_uart_we;
  logic [15:0] d1_ram_addr;
  logic [1:0]  d1_vga_addr;

  always #5 clk = ~clk;

  bus_decoder #(.RAM_WAIT(0), .TIMEOUT(15)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_addr(addr), .i_dat(wdat), .i_cs(cs), .i_we(we),
    .o_dat(d0_dat), .o_ack(d0_ack), .o_buserr(d0_buserr),
    .o_ram_addr(d0_ram_addr), .o_ram_dat(d0_ram_dat), .i_ram_dat(ram_dat),
    .o_ram_cs(d0_ram_cs), .o_ram_we(d0_ram_we),
    .o_vga_addr(d0_vga_addr), .o_vga_dat(d0_vga_dat), .i_vga_dat(vga_dat),
    .o_vga_cs(d0_vga_cs), .o_vga_we(d0_vga_we),
    .o_uart_addr(d0_uart_addr), .o_uart_dat(d0_uart_dat), .i_uart_dat(uart_dat),
    .o_uart_cs(d0_uart_cs), .o_uart_we(d0_uart_we), .i_uart_ack(uart_ack)
  );

  bus_decoder #(.RAM_WAIT(3), .TIMEOUT(15)) u_dut_w3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_addr(addr), .i_dat(wdat), .i_cs(cs1), .i_we(we),
    .o_dat(d1_dat), .o_ack(d1_ack), .o_buserr(d1_buserr),
    .o_ram_addr(d1_ram_addr), .o_ram_dat(d1_ram_dat), .i_ram_dat(ram_dat),
    .o_ram_cs(d1_ram_cs), .o_ram_we(d1_ram_we),
    .o_vga_addr(d1_vga_addr), .o_vga_dat(d1_vga_dat), .i_vga_dat(vga_dat),
    .o_vga_cs(d1_vga_cs), .o_vga_we(d1_vga_we),
    .o_uart_addr(d1_uart_addr), .o_uart_dat(d1_uart_dat), .i_uart_dat(uart_dat),
    .o_uart_cs(d1_uart_cs), .o_uart_we(d1_uart_we), .i_uart_ack(uart_ack)
  );

  logic [58:0] d0_all;
  logic [58:0] d1_all;
  assign d0_all = {d0_dat, d0_ack, d0_buserr, d0_ram_addr, d0_ram_dat, d0_ram_cs, d0_ram_we,
                   d0_vga_addr, d0_vga_dat, d0_vga_cs, d0_vga_we,
                   d0_uart_addr, d0_uart_dat, d0_uart_cs, d0_uart_we};
  assign d1_all = {d1_dat, d1_ack, d1_buserr, d1_ram_addr, d1_ram_dat, d1_ram_cs, d1_ram_we,
                   d1_vga_addr, d1_vga_dat, d1_vga_cs, d1_vga_we,
                   d1_uart_addr, d1_uart_dat, d1_uart_cs, d1_uart_we};

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdat;
    logic        we;
    logic [7:0]  ram_rd;
    logic [7:0]  vga_rd;
    logic [7:0]  uart_rd;
    int          ud;       // cycles after request until i_uart_ack; 0 = never
    int          lat;
    logic [7:0]  exp_dat;
    logic        exp_err;
    int          tgt;
    int          ncs;
  } vec_t;

  typedef struct {
    logic [7:0] dat;
    logic       err;
    int         cyc;
  } exp_t;

  vec_t        vt[16];
  exp_t        sb[$];
  exp_t        sb_e;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          ack_cnt  = 0;
  int          cs_cnt[3];
  logic [15:0] cap_addr;
  logic [7:0]  cap_wdat;
  logic        cap_we;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer and per-cycle bus observer for the RAM_WAIT=0 instance.
  always @(negedge clk) begin
    chk("single_target_cs", 64'($countones({d0_ram_cs, d0_vga_cs, d0_uart_cs}) > 1), 64'd0);
    chk("buserr_without_ack", 64'(d0_buserr & ~d0_ack), 64'd0);
    if (d0_ram_cs) begin
      cs_cnt[0]++; cap_addr = d0_ram_addr; cap_we = d0_ram_we; cap_wdat = d0_ram_dat;
    end
    if (d0_vga_cs) begin
      cs_cnt[1]++; cap_addr = {14'd0, d0_vga_addr}; cap_we = d0_vga_we; cap_wdat = d0_vga_dat;
    end
    if (d0_uart_cs) begin
      cs_cnt[2]++; cap_addr = {15'd0, d0_uart_addr}; cap_we = d0_uart_we; cap_wdat = d0_uart_dat;
    end
    if (d0_ack) begin
      ack_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
      end else begin
        sb_e = sb.pop_front();
        chk("ack_dat", 64'(d0_dat), 64'(sb_e.dat));
        chk("ack_buserr", 64'(d0_buserr), 64'(sb_e.err));
        chk("ack_cycle", 64'(cyc), 64'(sb_e.cyc));
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    int d;
    bit got;
    @(posedge clk); #1;
    cs_cnt[0] = 0; cs_cnt[1] = 0; cs_cnt[2] = 0;
    cap_addr = 16'h0; cap_we = 1'b0; cap_wdat = 8'h0;
    addr = v.addr; wdat = v.wdat; we = v.we;
    ram_dat = v.ram_rd; vga_dat = v.vga_rd; uart_dat = v.uart_rd;
    uart_ack = 1'b0;
    cs = 1'b1;
    d = cyc;
    sb.push_back('{v.exp_dat, v.exp_err, d + v.lat});
    got = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      uart_ack = (v.ud != 0) && (k == v.ud);
      if (d0_ack) begin
        got = 1'b1;
        break;
      end
    end
    cs = 1'b0; we = 1'b0; uart_ack = 1'b0; addr = 16'hFE08; wdat = 8'hEE;
    chk($sformatf("v%0d_ack_seen", idx), 64'(got), 64'd1);
    if (!got) sb.delete();
    @(negedge clk); #1;
    chk($sformatf("v%0d_ram_cs_cycles", idx), 64'(cs_cnt[0]), 64'((v.tgt == T_RAM) ? v.ncs : 0));
    chk($sformatf("v%0d_vga_cs_cycles", idx), 64'(cs_cnt[1]), 64'((v.tgt == T_VGA) ? v.ncs : 0));
    chk($sformatf("v%0d_uart_cs_cycles", idx), 64'(cs_cnt[2]), 64'((v.tgt == T_UART) ? v.ncs : 0));
    if (v.tgt != T_NONE) begin
      chk($sformatf("v%0d_target_addr", idx), 64'(cap_addr),
          64'((v.tgt == T_RAM) ? v.addr : ((v.tgt == T_VGA) ? {14'd0, v.addr[1:0]} :
                                                             {15'd0, v.addr[0]})));
      chk($sformatf("v%0d_target_we", idx), 64'(cap_we), 64'(v.we));
      if (v.we) chk($sformatf("v%0d_target_wdat", idx), 64'(cap_wdat), 64'(v.wdat));
    end
  endtask

  // Drives one access into the RAM_WAIT=3 instance; lat = -1 when no ack arrives.
  task automatic w3_access(input logic [15:0] a, input logic [7:0] wd, input logic w,
                           output int lat, output int n, output logic [7:0] odat,
                           output logic oerr, output logic [15:0] caddr, output logic [7:0] cdat);
    int d;
    @(posedge clk); #1;
    addr = a; wdat = wd; we = w; cs1 = 1'b1;
    d = cyc; lat = -1; n = 0; odat = 8'h0; oerr = 1'b0; caddr = 16'h0; cdat = 8'h0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (d1_ram_cs && (d1_ram_we == w)) begin
        n++; caddr = d1_ram_addr; cdat = d1_ram_dat;
      end
      if (d1_ack) begin
        lat = cyc - d; odat = d1_dat; oerr = d1_buserr;
        break;
      end
    end
    cs1 = 1'b0; we = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, n, a0;
    logic [7:0]  od, dat0;
    logic        oe;
    logic [15:0] ca;
    logic [7:0]  cd;

    //          addr      wdat  we    ram    vga    uart   ud  lat  exp    err   tgt     ncs
    vt[0]  = '{16'h1234, 8'h00, 1'b0, 8'h5A, 8'h00, 8'h00, 0,  2,  8'h5A, 1'b0, T_RAM,  1};
    vt[1]  = '{16'hFE01, 8'h41, 1'b1, 8'h00, 8'h00, 8'h00, 0,  2,  8'h5A, 1'b0, T_VGA,  1};
    vt[2]  = '{16'hFE02, 8'h00, 1'b0, 8'h00, 8'h07, 8'h00, 0,  2,  8'h07, 1'b0, T_VGA,  1};
    vt[3]  = '{16'hFE11, 8'h00, 1'b0, 8'h00, 8'h00, 8'h33, 4,  5,  8'h33, 1'b0, T_UART, 4};
    vt[4]  = '{16'hFE11, 8'h00, 1'b0, 8'h00, 8'h00, 8'h44, 0,  17, 8'hFF, 1'b1, T_UART, 16};
    vt[5]  = '{16'hFE08, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 0,  2,  8'hFF, 1'b1, T_NONE, 0};
    vt[6]  = '{16'hFE10, 8'h99, 1'b1, 8'h00, 8'h00, 8'h00, 2,  3,  8'hFF, 1'b0, T_UART, 2};
    vt[7]  = '{16'hBEEF, 8'h12, 1'b1, 8'h00, 8'h00, 8'h00, 0,  2,  8'hFF, 1'b0, T_RAM,  1};
    vt[8]  = '{16'h0000, 8'h00, 1'b0, 8'h3C, 8'h00, 8'h00, 0,  2,  8'h3C, 1'b0, T_RAM,  1};
    vt[9]  = '{16'hFE04, 8'h77, 1'b1, 8'h00, 8'h00, 8'h00, 0,  2,  8'h3C, 1'b1, T_NONE, 0};
    vt[10] = '{16'hFDFF, 8'h00, 1'b0, 8'h81, 8'h00, 8'h00, 0,  2,  8'h81, 1'b0, T_RAM,  1};
    vt[11] = '{16'hFF00, 8'h00, 1'b0, 8'h18, 8'h00, 8'h00, 0,  2,  8'h18, 1'b0, T_RAM,  1};
    vt[12] = '{16'hFE03, 8'h00, 1'b0, 8'h00, 8'hC3, 8'h00, 0,  2,  8'hC3, 1'b0, T_VGA,  1};
    vt[13] = '{16'hFE12, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 0,  2,  8'hFF, 1'b1, T_NONE, 0};
    vt[14] = '{16'hFE10, 8'h00, 1'b0, 8'h00, 8'h00, 8'h5E, 1,  2,  8'h5E, 1'b0, T_UART, 1};
    vt[15] = '{16'hFE11, 8'h00, 1'b0, 8'h00, 8'h00, 8'h6D, 16, 17, 8'h6D, 1'b0, T_UART, 16};

    rst_n = 1'b0; cs = 1'b1; cs1 = 1'b1; we = 1'b0; addr = 16'h1234; wdat = 8'h00;
    ram_dat = 8'h5A; vga_dat = 8'h00; uart_dat = 8'h00; uart_ack = 1'b0;
    cs_cnt[0] = 0; cs_cnt[1] = 0; cs_cnt[2] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'(d0_all), 64'd0);
    chk("reset_outputs_w3", 64'(d1_all), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_release_outputs", 64'(d0_all), 64'd0);
    cs = 1'b0; cs1 = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 16; i++) run_vec(i, vt[i]);

    // Back-to-back RAM reads with i_cs held: acks three cycles apart.
    @(posedge clk); #1;
    addr = 16'h0010; ram_dat = 8'h11; we = 1'b0; cs = 1'b1;
    a0 = cyc;
    sb.push_back('{8'h11, 1'b0, a0 + 2});
    sb.push_back('{8'h22, 1'b0, a0 + 5});
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (d0_ack) begin
        n++;
        if (n == 1) begin
          addr = 16'h0020; ram_dat = 8'h22;
        end else begin
          break;
        end
      end
    end
    cs = 1'b0;
    chk("b2b_ack_count", 64'(n), 64'd2);
    @(negedge clk); #1;

    // Master drops i_cs mid UART access: target side finishes, no ack, o_dat kept.
    @(posedge clk); #1;
    addr = 16'hFE11; we = 1'b0; uart_dat = 8'h99; uart_ack = 1'b0; cs = 1'b1;
    a0 = ack_cnt; dat0 = d0_dat;
    repeat (3) @(posedge clk);
    #1;
    cs = 1'b0;
    @(posedge clk); #1;
    chk("abort_uart_cs_held", 64'(d0_uart_cs), 64'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_ack", 64'(ack_cnt - a0), 64'd0);
    chk("abort_dat_kept", 64'(d0_dat), 64'(dat0));
    chk("abort_uart_cs_released", 64'(d0_uart_cs), 64'd0);

    // RAM_WAIT=3 instance: write then read.
    ram_dat = 8'h00;
    w3_access(16'h0100, 8'hA5, 1'b1, lat, n, od, oe, ca, cd);
    chk("w3_wr_latency", 64'(lat), 64'd5);
    chk("w3_wr_cs_we_cycles", 64'(n), 64'd4);
    chk("w3_wr_dat_unchanged", 64'(od), 64'h00);
    chk("w3_wr_buserr", 64'(oe), 64'd0);
    chk("w3_wr_ram_addr", 64'(ca), 64'h0100);
    chk("w3_wr_ram_dat", 64'(cd), 64'hA5);
    ram_dat = 8'h77;
    w3_access(16'h0200, 8'h00, 1'b0, lat, n, od, oe, ca, cd);
    chk("w3_rd_latency", 64'(lat), 64'd5);
    chk("w3_rd_cs_cycles", 64'(n), 64'd4);
    chk("w3_rd_dat", 64'(od), 64'h77);
    chk("w3_rd_ram_addr", 64'(ca), 64'h0200);

    // Reset during the RAM wait: cs drops asynchronously, no ack afterwards.
    @(posedge clk); #1;
    addr = 16'h0300; we = 1'b0; cs1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("w3_cs_before_reset", 64'(d1_ram_cs), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("w3_cs_async_drop", 64'(d1_ram_cs), 64'd0);
    cs1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (d1_ack) n++;
    end
    chk("w3_no_ack_after_reset", 64'(n), 64'd0);
    chk("dat_cleared_by_reset", 64'(d0_dat), 64'h00);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
